// File: rtl/data_change_capture_pkg.sv
// Shared defaults and the queued entry record for the data change capture block.
package data_change_capture_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TS_W_DEF   = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int DROP_W     = 8;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [TS_W_DEF-1:0]   ts;
    } entry_t;

endpackage

// File: rtl/capture_fifo.sv
// First-word fall-through FIFO; head word is read straight from storage and forced to 0 when empty.
module capture_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iPushData,
    input  logic             iPop,
    output logic             oFull,
    output logic             oEmpty,
    output logic [AW:0]      oCount,
    output logic [WIDTH-1:0] oHeadData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    // Pointers carry one extra bit so full and empty are distinguishable when indices match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = iPop && !w_empty;
    assign w_do_push = iPush && (!w_full || w_do_pop);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide what is valid, so a reset array would only cost flops.
    always_ff @(posedge iClk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= iPushData;
    end

    assign oFull     = w_full;
    assign oEmpty    = w_empty;
    assign oCount    = r_wr_ptr - r_rd_ptr;
    assign oHeadData = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/data_change_capture.sv
// Captures {data, timestamp} into a FIFO whenever the enabled input word changes; counts drops on overflow.
module data_change_capture
    import data_change_capture_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int TS_W   = TS_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iEn,
    input  logic              iClr,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic [TS_W-1:0]   oTs,
    output logic [CNT_W-1:0]  oCount,
    output logic              oOverflow,
    output logic [DROP_W-1:0] oDropCnt
);

    logic [TS_W-1:0]        r_ts;
    logic [DATA_W-1:0]      r_prev;
    logic                   r_first;
    logic                   r_overflow;
    logic [DROP_W-1:0]      r_drop_cnt;
    logic                   w_change;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [DATA_W+TS_W-1:0] w_head;

    assign w_change = iEn && (r_first || (iData != r_prev));
    assign w_pop    = iReady && !w_empty;
    assign w_push   = w_change && (!w_full || w_pop);
    assign w_drop   = w_change && w_full && !w_pop;

    // r_first is re-armed by every disabled cycle, so each enable episode captures its first sample.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_ts    <= '0;
            r_prev  <= '0;
            r_first <= 1'b1;
        end else begin
            r_ts    <= r_ts + TS_W'(1);
            r_first <= !iEn;
            if (iEn) r_prev <= iData;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (iClr)
                r_drop_cnt <= DROP_W'(1);
            else if (r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end else if (iClr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    capture_fifo #(
        .WIDTH (DATA_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .iPush     (w_push),
        .iPushData ({iData, r_ts}),
        .iPop      (w_pop),
        .oFull     (w_full),
        .oEmpty    (w_empty),
        .oCount    (oCount),
        .oHeadData (w_head)
    );

    assign oValid        = !w_empty;
    assign {oData, oTs}  = w_head;
    assign oOverflow     = r_overflow;
    assign oDropCnt      = r_drop_cnt;

endmodule

// File: tb/tb_data_change_capture.sv
// Scoreboard bench: stimulus predicts entries into a queue, a negedge monitor checks every pop.
module tb_data_change_capture;
    import data_change_capture_pkg::*;

    localparam int DATA_W = DATA_W_DEF;
    localparam int TS_W   = TS_W_DEF;
    localparam int DEPTH  = DEPTH_DEF;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              iClk = 1'b0;
    logic              iRst = 1'b1;
    logic [DATA_W-1:0] iData = '0;
    logic              iEn = 1'b0;
    logic              iClr = 1'b0;
    logic              iReady = 1'b0;
    logic              oValid;
    logic [DATA_W-1:0] oData;
    logic [TS_W-1:0]   oTs;
    logic [CNT_W-1:0]  oCount;
    logic              oOverflow;
    logic [7:0]        oDropCnt;

    always #5 iClk = ~iClk;

    data_change_capture dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iData     (iData),
        .iEn       (iEn),
        .iClr      (iClr),
        .oValid    (oValid),
        .iReady    (iReady),
        .oData     (oData),
        .oTs       (oTs),
        .oCount    (oCount),
        .oOverflow (oOverflow),
        .oDropCnt  (oDropCnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected queue contents plus the block's visible status.
    entry_t            sb[$];
    int                m_cnt = 0;
    logic [DATA_W-1:0] m_prev = '0;
    bit                m_prev_en = 1'b0;
    logic [TS_W-1:0]   m_ts = '0;
    bit                m_ovf = 1'b0;
    int                m_drop = 0;

    logic [TS_W-1:0]   popped_ts[$];
    logic [TS_W-1:0]   last_ts = '0;
    bit                have_last = 1'b0;
    bit                saw_wrap = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge iClk) begin
        entry_t e;
        if (!iRst && oValid && iReady) begin
            if (sb.size() == 0) begin
                check("pop_without_expected_entry", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("pop_data", 64'(oData), 64'(e.data));
                check("pop_ts", 64'(oTs), 64'(e.ts));
                popped_ts.push_back(oTs);
                if (have_last && last_ts == '1 && oTs == '0) saw_wrap = 1'b1;
                last_ts   = oTs;
                have_last = 1'b1;
            end
        end
    end

    // Called just after a rising edge: check visible status, apply inputs, predict the next edge.
    task automatic drive(input logic [DATA_W-1:0] d, input bit en, input bit rdy, input bit clr);
        bit pop;
        bit chg;
        bit drop;
        check("count", 64'(oCount), 64'(m_cnt));
        check("valid", 64'(oValid), 64'(m_cnt > 0));
        check("overflow", 64'(oOverflow), 64'(m_ovf));
        check("drop_cnt", 64'(oDropCnt), 64'(m_drop));
        if (m_cnt == 0) check("empty_readout", 64'({oData, oTs}), 64'(0));
        iData  = d;
        iEn    = en;
        iReady = rdy;
        iClr   = clr;
        pop  = rdy && (m_cnt > 0);
        chg  = en && (!m_prev_en || d != m_prev);
        drop = chg && (m_cnt == DEPTH) && !pop;
        if (chg && !drop) begin
            sb.push_back('{data: d, ts: m_ts});
            m_cnt++;
        end
        if (pop) m_cnt--;
        if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        if (en) m_prev = d;
        m_prev_en = en;
        m_ts      = m_ts + 1'b1;
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        #1;
        check("rst_valid", 64'(oValid), 64'(0));
        check("rst_count", 64'(oCount), 64'(0));
        check("rst_data", 64'(oData), 64'(0));
        check("rst_ts", 64'(oTs), 64'(0));
        check("rst_overflow", 64'(oOverflow), 64'(0));
        check("rst_drop_cnt", 64'(oDropCnt), 64'(0));
        sb.delete();
        m_cnt = 0; m_prev = '0; m_prev_en = 1'b0; m_ts = '0; m_ovf = 1'b0; m_drop = 0;
        iEn = 1'b0; iReady = 1'b0; iClr = 1'b0; iData = '0;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wcnt;
        do_reset();

        // Held value after reset: a single entry stamped at time 0.
        for (int i = 0; i < 5; i++) drive('0, 1'b1, 1'b0, 1'b0);
        check("hold_zero_count", 64'(oCount), 64'(1));
        check("hold_zero_data", 64'(oData), 64'(0));
        check("hold_zero_ts", 64'(oTs), 64'(0));
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b1, 1'b0);

        // Stepped values with a ready consumer: six pops, timestamps 5 apart.
        popped_ts.delete();
        for (int v = 0; v < 6; v++)
            for (int k = 0; k < 5; k++) drive(DATA_W'(v * 10), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b1, 1'b0);
        check("steps_popped", 64'(popped_ts.size()), 64'(6));
        for (int i = 1; i < popped_ts.size(); i++)
            check("steps_ts_spacing", 64'(TS_W'(popped_ts[i] - popped_ts[i-1])), 64'(5));

        // Overflow: 12 changes into an 8-deep FIFO, then clear.
        for (int i = 0; i < 12; i++) drive(DATA_W'(100 + i), 1'b1, 1'b0, 1'b0);
        check("ovf_count", 64'(oCount), 64'(8));
        check("ovf_flag", 64'(oOverflow), 64'(1));
        check("ovf_drops", 64'(oDropCnt), 64'(4));
        drive(DATA_W'(111), 1'b1, 1'b0, 1'b1);
        check("clr_flag", 64'(oOverflow), 64'(0));
        check("clr_drops", 64'(oDropCnt), 64'(0));
        check("clr_count", 64'(oCount), 64'(8));

        // Full with push and pop together: accepted; then drop coinciding with clear.
        drive(DATA_W'(500), 1'b1, 1'b1, 1'b0);
        check("full_pushpop_count", 64'(oCount), 64'(8));
        check("full_pushpop_drops", 64'(oDropCnt), 64'(0));
        drive(DATA_W'(501), 1'b1, 1'b0, 1'b1);
        check("drop_beats_clr_flag", 64'(oOverflow), 64'(1));
        check("drop_beats_clr_cnt", 64'(oDropCnt), 64'(1));
        for (int i = 0; i < 10; i++) drive(DATA_W'(501), 1'b0, 1'b1, 1'b0);

        // Random traffic on a narrow data range so repeats and changes both occur.
        for (int i = 0; i < 400; i++)
            drive(DATA_W'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        for (int i = 0; i < 10; i++) drive('0, 1'b0, 1'b1, 1'b0);

        // Drop counter saturation.
        drive('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 270; i++) drive(DATA_W'(i + 1), 1'b1, 1'b0, 1'b0);
        check("drop_saturate", 64'(oDropCnt), 64'(255));
        drive(DATA_W'(270), 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive('0, 1'b0, 1'b1, 1'b0);

        // Timestamp wrap with sparse changes clustered around 65535 -> 0.
        have_last = 1'b0;
        saw_wrap  = 1'b0;
        wcnt      = 0;
        for (int i = 0; i < 65540; i++) begin
            if (m_ts % 8000 == 0 || m_ts >= 16'hFFFE || m_ts <= 16'd1) wcnt++;
            drive(DATA_W'(32'h1000_0000 + wcnt), 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b1, 1'b0);
        check("ts_wrap_seen", 64'(saw_wrap), 64'(1));

        // Reset mid-operation with five entries queued and a pop pending.
        for (int i = 0; i < 5; i++) drive(DATA_W'(200 + i), 1'b1, 1'b0, 1'b0);
        check("prereset_count", 64'(oCount), 64'(5));
        iReady = 1'b1;
        #2;
        do_reset();
        drive('0, 1'b1, 1'b0, 1'b0);
        check("post_reset_count", 64'(oCount), 64'(1));
        check("post_reset_data", 64'(oData), 64'(0));
        check("post_reset_ts", 64'(oTs), 64'(0));
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b1, 1'b0);
        check("final_queue_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
